// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared state encoding, RV32I load/store width codes and the
//               request legality check for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; halfwords and words must be naturally aligned.
    function automatic logic lsu_legal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !addr_lo[0];
            F3_HU:   ok = !is_store && !addr_lo[0];
            F3_W:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/halfword of a load response word
//               and sign- or zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_B:    data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   data = {24'd0, w_byte};
            F3_H:    data = {{16{w_half[15]}}, w_half};
            F3_HU:   data = {16'd0, w_half};
            default: data = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory access stage: legality check, valid/ready bus
//               transaction, load alignment and register-file writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              lsu_err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              wb_we,
    output logic [4:0]        wb_wa,
    output logic [DATA_W-1:0] wb_wd
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic              r_is_store;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_ldata;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_wstrb;
    logic [DATA_W-1:0] r_bus_wdata;

    logic              w_legal;
    logic              w_accept;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ldata;

    assign w_legal  = lsu_legal(req_is_store, req_funct3, req_addr[1:0]);
    assign w_accept = (r_state == IDLE) && req_valid && w_legal;

    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3)
            F3_B: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                w_wstrb = 4'b0011 << {req_addr[1], 1'b0};
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .rdata   (bus_rdata),
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .data    (w_ldata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr_lo   <= 2'd0;
            r_rd        <= 5'd0;
            r_ldata     <= '0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wstrb <= 4'd0;
            r_bus_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_store  <= req_is_store;
                r_funct3    <= req_funct3;
                r_addr_lo   <= req_addr[1:0];
                r_rd        <= req_rd;
                r_bus_we    <= req_is_store;
                r_bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                r_bus_wstrb <= req_is_store ? w_wstrb : 4'd0;
                r_bus_wdata <= req_is_store ? w_wdata : '0;
            end
            if ((r_state == WAIT_RSP) && bus_rvalid) begin
                r_ldata <= w_ldata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        lsu_err     = 1'b0;
        bus_valid   = 1'b0;
        wb_we       = 1'b0;
        wb_wa       = 5'd0;
        wb_wd       = '0;
        case (r_state)
            IDLE: begin
                // Gated by reset so the combinational responses stay low while reset is held.
                if (req_valid && reset) begin
                    if (w_legal) begin
                        stall       = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        lsu_err = 1'b1;
                    end
                end
            end
            REQ: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                if (bus_ready) begin
                    w_state_nxt = r_is_store ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                stall = 1'b1;
                if (bus_rvalid) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!r_is_store) begin
                    wb_we = (r_rd != 5'd0);
                    wb_wa = r_rd;
                    wb_wd = r_ldata;
                end
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit with a transaction
//               timeline model and randomized loads/stores.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, lsu_err, bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata, wb_wd;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid, wb_we;
    logic [4:0]  wb_wa;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .stall        (stall),
        .lsu_err      (lsu_err),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .wb_we        (wb_we),
        .wb_wa        (wb_wa),
        .wb_wd        (wb_wd)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_legal(input bit st, input int f3, input int lo);
        case (f3)
            0:       return 1'b1;
            1:       return (lo % 2) == 0;
            2:       return lo == 0;
            4:       return !st;
            5:       return !st && ((lo % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] m_strb(input int f3, input int lo);
        if (f3 == 0) return 4'(1 << lo);
        if (f3 == 1) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
        if (f3 == 0) return d[7:0] * 32'h0101_0101;
        if (f3 == 1) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input int f3, input int lo);
        logic [31:0] sh;
        int v;
        sh = w >> (8 * lo);
        case (f3)
            0: begin v = int'(sh & 32'hFF);   if (v > 127)   v -= 256;   return 32'(v); end
            4: return sh & 32'hFF;
            1: begin v = int'(sh & 32'hFFFF); if (v > 32767) v -= 65536; return 32'(v); end
            5: return sh & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    // Per-cycle expectations, written by the driver and checked at the falling edge.
    logic        e_on = 1'b0;
    logic        e_stall, e_err, e_bv, e_bwe, e_bdata, e_wb_we, e_wb_chk;
    logic [31:0] e_addr, e_wdata, e_wd;
    logic [3:0]  e_strb;
    logic [4:0]  e_wa;

    always @(negedge clk) begin
        if (e_on) begin
            chk("stall", stall, e_stall);
            chk("lsu_err", lsu_err, e_err);
            chk("bus_valid", bus_valid, e_bv);
            if (e_bv) begin
                chk("bus_we", bus_we, e_bwe);
                chk("bus_addr", bus_addr, e_addr);
                if (e_bdata) begin
                    chk("bus_wstrb", bus_wstrb, e_strb);
                    chk("bus_wdata", bus_wdata, e_wdata);
                end
            end
            chk("wb_we", wb_we, e_wb_we);
            if (e_wb_chk) begin
                chk("wb_wa", wb_wa, e_wa);
                chk("wb_wd", wb_wd, e_wd);
            end
        end
    end

    task automatic exp_quiet();
        e_stall = 0; e_err = 0; e_bv = 0; e_bwe = 0; e_bdata = 0;
        e_wb_we = 0; e_wb_chk = 1; e_wa = 0; e_wd = 0;
        e_addr = 0; e_wdata = 0; e_strb = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
            bus_ready = 1'($urandom); bus_rvalid = 1'($urandom); bus_rdata = $urandom;
            exp_quiet();
            e_on = 1;
            @(posedge clk); #1;
        end
    endtask

    // One instruction from IDLE to retirement; dr = ready wait cycles, dv = extra response wait cycles.
    task automatic access(input bit st, input int f3, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] rd, input int dr, input int dv, input logic [31:0] rdata);
        int lo;
        bit legal;
        int last;
        lo    = int'(addr[1:0]);
        legal = m_legal(st, f3, lo);
        last  = !legal ? 0 : (st ? 2 + dr : 3 + dr + dv);
        for (int k = 0; k <= last; k++) begin
            req_valid = 1; req_is_store = st; req_funct3 = 3'(f3);
            req_addr = addr; req_wdata = wd; req_rd = rd;
            bus_ready = 0; bus_rvalid = 0; bus_rdata = $urandom;
            exp_quiet();
            if (!legal) begin
                e_err = 1;
                bus_ready = 1'($urandom); bus_rvalid = 1'($urandom);
            end else if (k == 0) begin
                e_stall = 1;
                bus_ready = 1'($urandom); bus_rvalid = 1'($urandom);
            end else if (k <= 1 + dr) begin
                e_stall = 1; e_bv = 1; e_bwe = st; e_bdata = st;
                e_addr = {addr[31:2], 2'b00};
                e_strb = m_strb(f3, lo);
                e_wdata = m_wdata(f3, wd);
                bus_ready = (k == 1 + dr);
                bus_rvalid = 1'($urandom);
            end else if (k < last) begin
                e_stall = 1;
                bus_ready = 1'($urandom);
                bus_rvalid = (k == last - 1);
                if (bus_rvalid) bus_rdata = rdata;
            end else begin
                e_wb_we = !st && (rd != 0);
                e_wb_chk = !st;
                e_wa = rd;
                e_wd = m_load(rdata, f3, lo);
                bus_ready = 1'($urandom); bus_rvalid = 1'($urandom);
            end
            e_on = 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_err"}, lsu_err, 0);
        chk({tag, "_bus_valid"}, bus_valid, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_wb_we"}, wb_we, 0);
        chk({tag, "_wb_wa"}, wb_wa, 0);
        chk({tag, "_wb_wd"}, wb_wd, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 0;
        req_valid = 1; req_is_store = 1; req_funct3 = 3'd2; req_addr = 32'h100;
        req_wdata = 32'h1234_5678; req_rd = 5'd1;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h5555_AAAA;

        // Model pins against hand-computed values.
        chk("pin_lb",  m_load(32'h1280_3456, 0, 2), 32'hFFFF_FF80);
        chk("pin_lbu", m_load(32'h1280_3456, 4, 2), 32'h0000_0080);
        chk("pin_lh",  m_load(32'h1280_3456, 1, 2), 32'h0000_1280);
        chk("pin_sb_strb", 32'(m_strb(0, 3)), 32'h8);
        chk("pin_sb_data", m_wdata(0, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("pin_lh_mis", 32'(m_legal(0, 1, 1)), 0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("reset");
        reset = 1;

        idle(2);
        access(1, 2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3, 0, 0, 0);
        access(1, 0, 32'h0000_0103, 32'h0000_00A5, 5'd3, 0, 0, 0);
        access(0, 0, 32'h0000_0202, 32'h0, 5'd7, 0, 0, 32'h1280_3456);
        access(0, 4, 32'h0000_0202, 32'h0, 5'd8, 0, 0, 32'h1280_3456);
        access(0, 1, 32'h0000_0202, 32'h0, 5'd9, 0, 0, 32'h1280_3456);
        access(0, 2, 32'h0000_0400, 32'h0, 5'd0, 0, 0, 32'hCAFE_F00D);
        access(0, 1, 32'h0000_0301, 32'h0, 5'd4, 0, 0, 0);
        access(0, 3, 32'h0000_0300, 32'h0, 5'd4, 0, 0, 0);
        access(1, 2, 32'h0000_0100, 32'h0BAD_F00D, 5'd2, 5, 0, 0);
        idle(1);

        // Reset while a load waits for its response.
        e_on = 0;
        req_valid = 1; req_is_store = 0; req_funct3 = 3'd2; req_addr = 32'h800; req_rd = 5'd12;
        bus_ready = 0; bus_rvalid = 0;
        @(posedge clk); #1;
        bus_ready = 1;
        @(posedge clk); #1;
        bus_ready = 0;
        #2;
        chk("wait_stall_pre", stall, 1);
        reset = 0;
        #1;
        chk_all_zero("rst_wait");
        @(posedge clk); #1;
        reset = 1; req_valid = 0; bus_rvalid = 1; bus_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_rvalid_wb_we", wb_we, 0);
            chk("stale_rvalid_stall", stall, 0);
            @(posedge clk); #1;
        end
        bus_rvalid = 0;

        // Reset while a store waits for bus_ready.
        req_valid = 1; req_is_store = 1; req_funct3 = 3'd2; req_addr = 32'h900; req_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        req_valid = 1;
        #2;
        chk("req_valid_pre", bus_valid, 1);
        reset = 0;
        #1;
        chk_all_zero("rst_req");
        @(posedge clk); #1;
        reset = 1;
        idle(2);

        for (int n = 0; n < 200; n++) begin
            logic [4:0] rd;
            rd = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
            access(1'($urandom), int'($urandom % 8), $urandom, $urandom, rd,
                   int'($urandom % 4), int'($urandom % 4), $urandom);
            idle(int'($urandom % 3));
        end

        e_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
